// File: rtl/bus_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_rr_if
//  Description : Request/grant bundle between the requesters and the
//                round-robin arbiter.
//                master = requester side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_rr_if #(
   parameter int N_REQ = 16,
   parameter int IDX_W = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output req,
      input  gnt, gnt_idx, gnt_valid, timeout
   );

   modport slave (
      input  req,
      output gnt, gnt_idx, gnt_valid, timeout
   );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_rr
//  Description : Round-robin arbiter for one shared resource. The owner keeps
//                the grant until it drops its request or the hold limit is
//                reached. An idle turnaround cycle always separates grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
   parameter int N_REQ    = 16,
   parameter int IDX_W    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic            clk,
   input  logic            rst,
   bus_arbiter_rr_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;

   // A counter wide enough to reach MAX_HOLD-1, never narrower than one bit
   localparam int              HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0] IDX_RST  = IDX_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   logic [0:0]       state, state_nxt;
   logic [HC_W-1:0]  hold_cnt, hold_nxt;
   logic [IDX_W-1:0] idx_q, idx_nxt;
   logic [N_REQ-1:0] gnt_q, gnt_nxt;
   logic             timeout_q, timeout_nxt;

   logic [IDX_W-1:0] winner;
   logic             found;
   logic             owner_req;
   logic             hold_expired;

   // Rotating search that starts just after the last owner, so the last
   // owner is always considered last.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      found  = 1'b0;
      winner = idx_q;
      cand   = 0;
      cand_idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand     = (int'(idx_q) + k) % N_REQ;
         cand_idx = IDX_W'(cand);
         if (!found && bus.req[cand_idx]) begin
            found  = 1'b1;
            winner = cand_idx;
         end
      end
   end

   assign owner_req    = bus.req[idx_q];
   assign hold_expired = (hold_cnt == HOLD_LAST);

   // State, hold counter, owner index and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         hold_cnt  <= '0;
         idx_q     <= IDX_RST;
         gnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         idx_q     <= idx_nxt;
         gnt_q     <= gnt_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   // Next-state: grant on any request in IDLE, release on drop or hold limit
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      idx_nxt   = idx_q;
      case (state)
         ST_IDLE: begin
            if (found) begin
               state_nxt = ST_OWN;
               hold_nxt  = '0;
               idx_nxt   = winner;
            end
         end
         ST_OWN: begin
            if (!owner_req || hold_expired) begin
               state_nxt = ST_IDLE;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode; a voluntary release takes precedence over the timeout
   always_comb begin
      gnt_nxt     = '0;
      timeout_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (found) begin
               gnt_nxt = ONE_HOT0 << winner;
            end
         end
         ST_OWN: begin
            if (owner_req && !hold_expired) begin
               gnt_nxt = gnt_q;
            end else if (owner_req) begin
               timeout_nxt = 1'b1;
            end
         end
         default: gnt_nxt = '0;
      endcase
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter_rr
//  Description : Self-checking bench for bus_arbiter_rr: directed scenarios
//                with literal expectations, then randomized requests checked
//                every cycle against a behavioural owner/last/held model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

   localparam int N        = 16;
   localparam int IW       = 4;
   localparam int MAX_HOLD = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: current owner (-1 = none), last granted index, cycles held so far
   int m_owner = -1;
   int m_last  = N - 1;
   int m_held  = 0;
   bit m_to    = 1'b0;

   bus_arbiter_rr_if #(.N_REQ(N), .IDX_W(IW)) bus ();

   bus_arbiter_rr #(.N_REQ(N), .IDX_W(IW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model advances on the same edge as the DUT
   always @(posedge clk) begin
      if (rst) begin
         m_owner <= -1;
         m_last  <= N - 1;
         m_held  <= 0;
         m_to    <= 1'b0;
      end else if (m_owner < 0) begin
         m_to <= 1'b0;
         if (bus.req != '0) begin
            m_owner <= pick(bus.req, m_last);
            m_last  <= pick(bus.req, m_last);
            m_held  <= 1;
         end
      end else if (!bus.req[m_owner]) begin
         m_owner <= -1;
         m_to    <= 1'b0;
      end else if (m_held == MAX_HOLD) begin
         m_owner <= -1;
         m_to    <= 1'b1;
      end else begin
         m_held <= m_held + 1;
         m_to   <= 1'b0;
      end
   end

   // Per-cycle comparison against the model
   always @(posedge clk) begin
      logic [N-1:0] eg;
      #1;
      if (chk_en) begin
         eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
         check("gnt",       32'(bus.gnt),       32'(eg));
         check("gnt_idx",   32'(bus.gnt_idx),   32'(m_last));
         check("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
         check("timeout",   32'(bus.timeout),   32'(m_to));
         check("onehot",    32'($countones(bus.gnt) <= 1), 32'(1));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // 1) reset with all requests asserted
      bus.req = 16'hFFFF;
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      check("t1_gnt", 32'(bus.gnt), 32'h0);
      check("t1_idx", 32'(bus.gnt_idx), 32'd15);
      tick();
      check("t1_valid", 32'(bus.gnt_valid), 32'h0);
      check("t1_timeout", 32'(bus.timeout), 32'h0);

      // 2) single requester 3, 3 grant cycles then drop
      rst = 1'b0;
      bus.req = 16'h0008;
      tick();
      check("t2_gnt", 32'(bus.gnt), 32'h0008);
      check("t2_idx", 32'(bus.gnt_idx), 32'd3);
      check("t2_model_last", 32'(m_last), 32'd3);
      tick();
      tick();
      bus.req = 16'h0000;
      tick();
      check("t2_release", 32'(bus.gnt), 32'h0);
      tick();

      // 3) requesters 0 and 5, each holds 2 cycles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req = 16'h0021;
      tick();
      check("t3_gnt0", 32'(bus.gnt), 32'h0001);
      tick();
      bus.req = 16'h0020;
      tick();
      check("t3_idle", 32'(bus.gnt), 32'h0);
      tick();
      check("t3_gnt5", 32'(bus.gnt), 32'h0020);
      check("t3_idx5", 32'(bus.gnt_idx), 32'd5);
      tick();
      bus.req = 16'h0000;
      tick();
      check("t3_release", 32'(bus.gnt), 32'h0);

      // 4) wrap from owner 15
      bus.req = 16'h8000;
      tick();
      check("t4_gnt15", 32'(bus.gnt), 32'h8000);
      bus.req = 16'h0000;
      tick();
      check("t4_idx_hold", 32'(bus.gnt_idx), 32'd15);
      bus.req = 16'h8004;
      tick();
      check("t4_gnt2", 32'(bus.gnt), 32'h0004);
      check("t4_idx2", 32'(bus.gnt_idx), 32'd2);
      bus.req = 16'h8000;
      tick();
      check("t4_turn", 32'(bus.gnt), 32'h0);
      tick();
      check("t4_gnt15b", 32'(bus.gnt), 32'h8000);
      bus.req = 16'h0000;
      tick();
      tick();

      // 5) hold limit with 0 and 8 both requesting
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req = 16'h0101;
      tick();
      check("t5_gnt0_c1", 32'(bus.gnt), 32'h0001);
      for (int i = 2; i <= MAX_HOLD; i++) begin
         tick();
         check("t5_gnt0_hold", 32'(bus.gnt), 32'h0001);
      end
      tick();
      check("t5_revoke", 32'(bus.gnt), 32'h0);
      check("t5_timeout", 32'(bus.timeout), 32'h1);
      check("t5_model_to", 32'(m_to), 32'h1);
      tick();
      check("t5_gnt8", 32'(bus.gnt), 32'h0100);
      check("t5_to_clear", 32'(bus.timeout), 32'h0);
      bus.req = 16'h0000;
      tick();
      tick();

      // 6) reset in the middle of ownership
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req = 16'h0001;
      tick();
      repeat (4) tick();
      check("t6_owning", 32'(bus.gnt), 32'h0001);
      rst = 1'b1;
      tick();
      check("t6_rst_gnt", 32'(bus.gnt), 32'h0);
      check("t6_rst_to", 32'(bus.timeout), 32'h0);
      rst = 1'b0;
      bus.req = 16'h0003;
      tick();
      check("t6_gnt0", 32'(bus.gnt), 32'h0001);
      check("t6_idx0", 32'(bus.gnt_idx), 32'd0);
      bus.req = 16'h0000;
      tick();

      // Randomized traffic; requests tend to persist so timeouts occur
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: bus.req = 16'h0000;
               1: bus.req = 16'(1) << $urandom_range(0, N - 1);
               2: bus.req = (16'(1) << $urandom_range(0, N - 1)) |
                            (16'(1) << $urandom_range(0, N - 1));
               default: bus.req = 16'($urandom);
            endcase
         end
         rst = ($urandom_range(0, 249) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
